// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet field offsets, PE mode encodings and the TX FSM state type.
package noc_pkg;

   localparam int unsigned NOC_DATA_WIDTH = 16;
   localparam int unsigned NOC_ADDR_WIDTH = 2;

   localparam int unsigned DATA_LSB = 0;
   localparam int unsigned SRC_LSB  = NOC_DATA_WIDTH;
   localparam int unsigned DST_LSB  = NOC_DATA_WIDTH + NOC_ADDR_WIDTH;

   localparam logic [1:0] MODE_ECHO = 2'd0;
   localparam logic [1:0] MODE_INCR = 2'd1;
   localparam logic [1:0] MODE_SINK = 2'd2;

   typedef enum logic {
      TX_IDLE,
      TX_SEND
   } tx_state_e;

   // Offsets for non-default geometries.
   function automatic int unsigned src_lsb(input int unsigned data_w);
      return data_w;
   endfunction

   function automatic int unsigned dst_lsb(input int unsigned data_w, input int unsigned addr_w);
      return data_w + addr_w;
   endfunction

endpackage

// File: rtl/pe_fifo.sv
// Generic synchronous FIFO with circular pointers; DEPTH must be a power of two (>= 2).
module pe_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/pe_nic.sv
// PE network interface: address check, receive FIFO, echo/increment/sink reply engine.
// Optional statistics counters are built when PE_STATS_EN is defined.
module pe_nic
   import noc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned LOCAL_ADDR = 0,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               i_valid_from_router,
   output logic                               o_ready_to_router,
   input  logic [DATA_WIDTH+2*ADDR_WIDTH-1:0] i_data_from_router,
   output logic                               o_valid_to_router,
   input  logic                               i_ready_from_router,
   output logic [DATA_WIDTH+2*ADDR_WIDTH-1:0] o_data_to_router,
   input  logic [1:0]                         i_mode,
`ifdef PE_STATS_EN
   output logic [CNT_WIDTH-1:0]               o_rx_cnt,
   output logic [CNT_WIDTH-1:0]               o_tx_cnt,
   output logic [CNT_WIDTH-1:0]               o_drop_cnt,
`endif
   output logic                               o_misroute
);

   localparam int unsigned PKT_W = DATA_WIDTH + 2 * ADDR_WIDTH;
   localparam int unsigned SRC_L = src_lsb(DATA_WIDTH);
   localparam int unsigned DST_L = dst_lsb(DATA_WIDTH, ADDR_WIDTH);

   logic                  w_full, w_empty;
   logic                  w_accept, w_is_local, w_push;
   logic                  w_pop, w_load, w_sink_pop, w_sink;
   logic [PKT_W-1:0]      w_head, w_reply;
   logic [DATA_WIDTH-1:0] w_reply_data;
   tx_state_e             r_state, w_state_nxt;
   logic [PKT_W-1:0]      r_data;
   logic                  r_misroute;

   assign o_ready_to_router = !w_full;
   assign w_accept          = i_valid_from_router && !w_full;
   assign w_is_local        = (i_data_from_router[DST_L +: ADDR_WIDTH] == ADDR_WIDTH'(LOCAL_ADDR));
   assign w_push            = w_accept && w_is_local;
   assign w_sink            = (i_mode == MODE_SINK) || (i_mode == 2'd3);

   pe_fifo #(
      .WIDTH (PKT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (i_data_from_router),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_reply_data = (i_mode == MODE_INCR) ? w_head[DATA_WIDTH-1:0] + 1'b1
                                               : w_head[DATA_WIDTH-1:0];
   assign w_reply      = {w_head[SRC_L +: ADDR_WIDTH], ADDR_WIDTH'(LOCAL_ADDR), w_reply_data};

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_load      = 1'b0;
      w_sink_pop  = 1'b0;
      case (r_state)
         TX_IDLE: begin
            if (!w_empty) begin
               w_pop = 1'b1;
               if (w_sink) begin
                  w_sink_pop = 1'b1;
               end else begin
                  w_load      = 1'b1;
                  w_state_nxt = TX_SEND;
               end
            end
         end
         TX_SEND: begin
            // A handshake may chain straight into the next reply, giving one packet per cycle.
            if (i_ready_from_router) begin
               if (!w_empty && !w_sink) begin
                  w_pop  = 1'b1;
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = TX_IDLE;
               end
            end
         end
         default: w_state_nxt = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= TX_IDLE;
         r_data     <= '0;
         r_misroute <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_misroute <= w_accept && !w_is_local;
         if (w_load) r_data <= w_reply;
      end
   end

   assign o_valid_to_router = (r_state == TX_SEND);
   assign o_data_to_router  = r_data;
   assign o_misroute        = r_misroute;

`ifdef PE_STATS_EN
   logic [CNT_WIDTH-1:0] r_rx_cnt, r_tx_cnt, r_drop_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_cnt   <= '0;
         r_tx_cnt   <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_rx_cnt   <= r_rx_cnt + CNT_WIDTH'(w_push);
         r_tx_cnt   <= r_tx_cnt + CNT_WIDTH'(o_valid_to_router && i_ready_from_router);
         // A misroute drop and a sink pop can land in the same cycle.
         r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(w_accept && !w_is_local) + CNT_WIDTH'(w_sink_pop);
      end
   end

   assign o_rx_cnt   = r_rx_cnt;
   assign o_tx_cnt   = r_tx_cnt;
   assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_pe_nic.sv
// Self-checking bench for pe_nic (LOCAL_ADDR=1): directed cases plus randomized traffic against a queue model.
module tb_pe_nic;

   localparam int LA = 1;
   localparam int PW = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_valid_from_router;
   logic          o_ready_to_router;
   logic [PW-1:0] i_data_from_router;
   logic          o_valid_to_router;
   logic          i_ready_from_router;
   logic [PW-1:0] o_data_to_router;
   logic [1:0]    i_mode;
   logic          o_misroute;
`ifdef PE_STATS_EN
   logic [15:0]   o_rx_cnt, o_tx_cnt, o_drop_cnt;
`endif

   always #5 clk = ~clk;

   pe_nic #(.LOCAL_ADDR(LA)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .i_valid_from_router (i_valid_from_router),
      .o_ready_to_router   (o_ready_to_router),
      .i_data_from_router  (i_data_from_router),
      .o_valid_to_router   (o_valid_to_router),
      .i_ready_from_router (i_ready_from_router),
      .o_data_to_router    (o_data_to_router),
      .i_mode              (i_mode),
`ifdef PE_STATS_EN
      .o_rx_cnt            (o_rx_cnt),
      .o_tx_cnt            (o_tx_cnt),
      .o_drop_cnt          (o_drop_cnt),
`endif
      .o_misroute          (o_misroute)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: expected replies in order, plus event counts.
   logic [PW-1:0] exp_q[$];
   int            m_rx = 0, m_tx = 0, m_drop = 0;
   bit            exp_mis = 0;
   bit            prev_stall = 0;
   logic [PW-1:0] prev_data = '0;

   function automatic logic [PW-1:0] reply_of(input logic [PW-1:0] p, input logic [1:0] mode);
      logic [15:0] d;
      d = p[15:0];
      if (mode == 2'd1) d = d + 16'd1;
      return {p[17:16], 2'(LA), d};
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         exp_mis    = 0;
         prev_stall = 0;
      end else begin
         check("misroute", {31'd0, o_misroute}, {31'd0, exp_mis});
         exp_mis = 0;
         if (prev_stall) begin
            check("stall_valid", {31'd0, o_valid_to_router}, 32'd1);
            check("stall_data", {12'd0, o_data_to_router}, {12'd0, prev_data});
         end
         if (i_valid_from_router && o_ready_to_router) begin
            if (i_data_from_router[19:18] == 2'(LA)) begin
               m_rx++;
               if (i_mode[1]) m_drop++;
               else exp_q.push_back(reply_of(i_data_from_router, i_mode));
            end else begin
               m_drop++;
               exp_mis = 1;
            end
         end
         if (o_valid_to_router && i_ready_from_router) begin
            m_tx++;
            check("tx_pending", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) check("tx_data", {12'd0, o_data_to_router}, {12'd0, exp_q.pop_front()});
         end
         prev_stall = o_valid_to_router && !i_ready_from_router;
         prev_data  = o_data_to_router;
      end
   end

   task automatic send_pkt(input logic [PW-1:0] pkt);
      bit ok = 0;
      @(posedge clk); #1;
      i_valid_from_router = 1'b1;
      i_data_from_router  = pkt;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (o_ready_to_router) begin ok = 1; break; end
      end
      check("send_accept", {31'd0, ok}, 32'd1);
      @(posedge clk); #1;
      i_valid_from_router = 1'b0;
   endtask

   task automatic expect_reply(input string tag, input logic [PW-1:0] exp);
      bit seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (o_valid_to_router) begin seen = 1; break; end
      end
      check({tag, "_seen"}, {31'd0, seen}, 32'd1);
      check(tag, {12'd0, o_data_to_router}, {12'd0, exp});
   endtask

   task automatic drain();
      bit done = 0;
      @(posedge clk); #1;
      i_valid_from_router = 1'b0;
      i_ready_from_router = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !o_valid_to_router) begin done = 1; break; end
      end
      check("drain", {31'd0, done}, 32'd1);
      repeat (6) @(negedge clk);
   endtask

   task automatic check_stats(input string tag);
`ifdef PE_STATS_EN
      check({tag, "_rx"}, {16'd0, o_rx_cnt}, 32'(16'(m_rx)));
      check({tag, "_tx"}, {16'd0, o_tx_cnt}, 32'(16'(m_tx)));
      check({tag, "_drop"}, {16'd0, o_drop_cnt}, 32'(16'(m_drop)));
`endif
   endtask

   initial begin
      rst = 1'b1;
      i_valid_from_router = 1'b0;
      i_data_from_router  = '0;
      i_ready_from_router = 1'b1;
      i_mode              = 2'd0;

      repeat (3) @(negedge clk);
      check("rst_valid", {31'd0, o_valid_to_router}, 32'd0);
      check("rst_data", {12'd0, o_data_to_router}, 32'd0);
      check("rst_ready", {31'd0, o_ready_to_router}, 32'd1);
      check("rst_misroute", {31'd0, o_misroute}, 32'd0);
      #2 rst = 1'b0;
      check_stats("rst");

      // ECHO latency: valid two cycles after the acceptance cycle, for one cycle.
      @(posedge clk); #1;
      i_valid_from_router = 1'b1;
      i_data_from_router  = 20'h600AB;
      @(posedge clk); #1;
      i_valid_from_router = 1'b0;
      @(negedge clk);
      check("echo_early", {31'd0, o_valid_to_router}, 32'd0);
      @(negedge clk);
      check("echo_valid", {31'd0, o_valid_to_router}, 32'd1);
      check("echo_data", {12'd0, o_data_to_router}, 32'h900AB);
      @(negedge clk);
      check("echo_one_cycle", {31'd0, o_valid_to_router}, 32'd0);

      // INCR with wrap
      i_mode = 2'd1;
      send_pkt(20'h6FFFF);
      expect_reply("incr_wrap", 20'h90000);
      send_pkt(20'h61234);
      expect_reply("incr", 20'h91235);
      drain();

      // Backpressure: 4 in FIFO plus 1 held in SEND
      i_mode = 2'd0;
      @(posedge clk); #1;
      i_ready_from_router = 1'b0;
      for (int k = 0; k < 5; k++) send_pkt(20'h60010 + 20'(k));
      @(negedge clk);
      check("bp_ready_low", {31'd0, o_ready_to_router}, 32'd0);
      check("bp_valid", {31'd0, o_valid_to_router}, 32'd1);
      check("bp_head", {12'd0, o_data_to_router}, 32'h90010);
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      i_ready_from_router = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_burst_valid", {31'd0, o_valid_to_router}, 32'd1);
         check("bp_burst_data", {12'd0, o_data_to_router}, 32'h90010 + k);
      end
      @(negedge clk);
      check("bp_burst_end", {31'd0, o_valid_to_router}, 32'd0);

      // Reset while a reply is held in SEND
      @(posedge clk); #1;
      i_ready_from_router = 1'b0;
      send_pkt(20'h600CD);
      expect_reply("pre_rst", 20'h900CD);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_valid", {31'd0, o_valid_to_router}, 32'd0);
      check("rst_mid_ready", {31'd0, o_ready_to_router}, 32'd1);
      exp_q.delete();
      m_rx = 0; m_tx = 0; m_drop = 0;
      @(negedge clk); #2;
      rst = 1'b0;
      i_ready_from_router = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rst_flushed", {31'd0, o_valid_to_router}, 32'd0);
      end
      check_stats("rst_mid");

      // Misroute
      send_pkt(20'hE0055);
      @(negedge clk);
      check("mis_pulse", {31'd0, o_misroute}, 32'd1);
      @(negedge clk);
      check("mis_end", {31'd0, o_misroute}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         check("mis_no_reply", {31'd0, o_valid_to_router}, 32'd0);
      end
`ifdef PE_STATS_EN
      check("mis_drop_cnt", {16'd0, o_drop_cnt}, 32'd1);
      check("mis_rx_cnt", {16'd0, o_rx_cnt}, 32'd0);
`endif

      // SINK
      i_mode = 2'd2;
      for (int k = 0; k < 3; k++) send_pkt(20'h60001 + 20'(k));
      drain();
`ifdef PE_STATS_EN
      check("sink_rx_cnt", {16'd0, o_rx_cnt}, 32'd3);
      check("sink_drop_cnt", {16'd0, o_drop_cnt}, 32'd4);
`endif
      check_stats("sink");

      // Randomized traffic per mode (ECHO, INCR, SINK, reserved)
      for (int m = 0; m < 4; m++) begin
         i_mode = 2'(m);
         for (int c = 0; c < 150; c++) begin
            logic [1:0]  dst;
            logic [15:0] d;
            @(posedge clk); #1;
            dst = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'(LA);
            d   = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
            i_valid_from_router = ($urandom_range(0, 9) < 7);
            i_data_from_router  = {dst, 2'($urandom), d};
            i_ready_from_router = ($urandom_range(0, 9) < 6);
         end
         drain();
         check_stats("rand");
      end

      check("final_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
